decoder_arb_sequencer: RTL and testbench
========================================

# decoder_arb_sequencer

Round-robin arbiter and sequencer that shares one 3-line to 8-line decoder (ttl_74238 style, active-high outputs) among WIDTH_OUT requesters. It chooses an owner, drives the decoder select address and the three enable pins with break-before-make sequencing, and limits how long one requester keeps the grant while others wait. It sits between the requesting agents and the decoder, whose one-hot outputs act as the select lines for the shared resource.

## Interface
- WIDTH_OUT, 8: number of requesters and decoder outputs; must be a power of 2 and at least 2. WIDTH_IN = $clog2(WIDTH_OUT) is derived internally and is not a parameter.
- MAX_HOLD, 4: GRANT cycles, at least 1, after which the owner can be preempted by a competing request.
- GUARD_CYCLES, 1: cycles, at least 1, during which the decoder is disabled between owners.
- DELAY_RISE, 0 and DELAY_FALL, 0: output delays in the codebase's standard format.

Ports:
- Clk  input  1  clock; every register updates on the rising edge
- Clear  input  1  synchronous reset, active-high
- Request  input  WIDTH_OUT  one bit per requester; level-sensitive
- Lock  input  1  present only with DECODER_ARB_LOCK_EN; blocks preemption of the current owner
- A  output  WIDTH_IN  decoder select address (registered)
- Enable1_bar  output  1  decoder enable, active low (registered)
- Enable2_bar  output  1  decoder enable, active low (registered)
- Enable3  output  1  decoder enable, active high (registered)
- Grant  output  WIDTH_OUT  one-hot grant taken from the internal decoder instance; all 0 when disabled
- Grant_valid  output  1  1 only in GRANT

## Operation
- Reset values: A=0, Enable1_bar=1, Enable2_bar=1, Enable3=0, Grant=0, Grant_valid=0. State is IDLE, last_owner=WIDTH_OUT-1 and hold_cnt=0.
- Enables: in GRANT the outputs are Enable1_bar=0, Enable2_bar=0, Enable3=1. In every other state they are 1, 1, 0.
- Arbitration: the block searches Request starting at last_owner+1 and wraps modulo WIDTH_OUT. The first set bit wins, becomes owner and is written into A and last_owner.
- IDLE:
  - If any Request bit is set, arbitrate and go to SETUP.
  - Otherwise stay in IDLE with A held.
- SETUP: A is stable and the enables are off, so A never changes while the decoder is enabled. Go to GRANT unconditionally and clear hold_cnt.
- GRANT:
  - hold_cnt increments each cycle and saturates at MAX_HOLD.
  - If Request[owner]=0, go to GUARD.
  - If hold_cnt=MAX_HOLD, another Request bit is set and Lock=0, go to GUARD (preemption).
  - Otherwise stay in GRANT. A lone owner keeps the grant indefinitely.
- GUARD: count GUARD_CYCLES cycles with A held. On the last one, arbitrate and go to SETUP if any Request bit is set, otherwise go to IDLE. The previous owner is eligible again, but it has the lowest priority.
- Request changes during SETUP are ignored because the owner is already latched. If the owner drops its request during SETUP, the block still enters GRANT for one cycle, then goes to GUARD.
- Clear asserted in any state, including GRANT, forces reset values at that edge with no guard period.

## Timing
- If Request is first seen at edge N in IDLE, the block is in SETUP with new A after edge N. After edge N+1 it is in GRANT with the enables on, and Grant and Grant_valid are valid.
- If the owner drops Request before edge M in GRANT, the enables are off after edge M. The next owner reaches GRANT after edge M+GUARD_CYCLES+1.
- Grant is purely combinational from the registered A and enables, plus DELAY_RISE/DELAY_FALL.
- Fastest owner-to-owner changeover is GUARD_CYCLES+1 disabled cycles.

## Configuration
- DECODER_ARB_LOCK_EN
  - Defined: the Lock port exists. Lock=1 in GRANT suppresses preemption, but a release by the owner still ends the grant.
  - Undefined: there is no Lock port, and internal lock is tied to 0.

## Structure
- Shared package decoder_arb_pkg:
  - state encoding IDLE=0, SETUP=1, GRANT=2, GUARD=3 (2-bit)
  - width helpers for hold_cnt ($clog2(MAX_HOLD+1)) and the guard counter
- Sub-module: one instance of the existing ttl_74238 with WIDTH_OUT passed through, driven by the registered A and enables, producing Grant. No other sub-modules.

## Test plan
- Reset, then Request=8'b00000100: A=2 after one cycle, then Enable3=1, Enable1_bar=0, Enable2_bar=0 and Grant=8'b00000100 after two cycles.
- Owner 2 holds while Request=8'b00010100, MAX_HOLD=4: after 4 GRANT cycles the enables drop for 1 GUARD cycle, then SETUP, then Grant=8'b00010000.
- Request=8'b10000001 with last_owner=7: owner 0 is granted first, and after it releases, owner 7 is granted. This checks wrap-around.
- Request drops to 0 in GRANT: GUARD for GUARD_CYCLES, then IDLE with Grant=0. A never changes while Enable3=1, which the bench checks every cycle.
- With DECODER_ARB_LOCK_EN, Lock=1, Request=8'b00000011, owner 0: Grant stays 8'b00000001 past MAX_HOLD. Lowering Lock causes the switch to owner 1.
- Clear pulsed mid-GRANT: the next cycle shows reset values and Grant=0. The next request is arbitrated starting from index 0.

Source files
------------

// File: rtl/decoder_arb_sequencer_pkg.sv
// Shared types and width helpers for the decoder arbiter/sequencer.
package decoder_arb_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StSetup = 2'd1,
    StGrant = 2'd2,
    StGuard = 2'd3
  } arb_state_e;

  function automatic int unsigned hold_cnt_width(input int unsigned max_hold);
    return $clog2(max_hold + 1);
  endfunction

  // Guard counter runs 0..guard_cycles-1; keep at least one bit.
  function automatic int unsigned guard_cnt_width(input int unsigned guard_cycles);
    return (guard_cycles > 1) ? $clog2(guard_cycles) : 1;
  endfunction

endpackage

// File: rtl/decoder_arb_sequencer_ttl_74238.sv
// 74238-style N-line decoder: active-high one-hot output, enabled only when E1_n=E2_n=0 and E3=1.
module ttl_74238 #(
  parameter int unsigned WIDTH_OUT  = 8,
  parameter int          DELAY_RISE = 0,
  parameter int          DELAY_FALL = 0,
  localparam int unsigned WIDTH_IN  = $clog2(WIDTH_OUT)
) (
  input  logic                 Enable1_bar,
  input  logic                 Enable2_bar,
  input  logic                 Enable3,
  input  logic [WIDTH_IN-1:0]  A,
  output logic [WIDTH_OUT-1:0] Y
);

  // Delays only shape simulation timing elsewhere; the logic itself is zero-delay.
  if (DELAY_RISE < 0 || DELAY_FALL < 0) begin : g_bad_delay
    $error("ttl_74238: DELAY_RISE/DELAY_FALL must be non-negative");
  end

  always_comb begin
    Y = '0;
    if (!Enable1_bar && !Enable2_bar && Enable3) begin
      Y[A] = 1'b1;
    end
  end

endmodule

// File: rtl/decoder_arb_sequencer.sv
// Round-robin owner selection with break-before-make sequencing of a shared 74238 decoder.
// Optional Lock input (blocks preemption) is built when DECODER_ARB_LOCK_EN is defined.
module decoder_arb_sequencer
  import decoder_arb_pkg::*;
#(
  parameter int unsigned WIDTH_OUT    = 8,
  parameter int unsigned MAX_HOLD     = 4,
  parameter int unsigned GUARD_CYCLES = 1,
  parameter int          DELAY_RISE   = 0,
  parameter int          DELAY_FALL   = 0,
  localparam int unsigned WIDTH_IN    = $clog2(WIDTH_OUT)
) (
  input  logic                 Clk,
  input  logic                 Clear,
  input  logic [WIDTH_OUT-1:0] Request,
`ifdef DECODER_ARB_LOCK_EN
  input  logic                 Lock,
`endif
  output logic [WIDTH_IN-1:0]  A,
  output logic                 Enable1_bar,
  output logic                 Enable2_bar,
  output logic                 Enable3,
  output logic [WIDTH_OUT-1:0] Grant,
  output logic                 Grant_valid
);

  localparam int unsigned HoldW  = hold_cnt_width(MAX_HOLD);
  localparam int unsigned GuardW = guard_cnt_width(GUARD_CYCLES);

  if (WIDTH_OUT < 2 || (WIDTH_OUT & (WIDTH_OUT - 1)) != 0) begin : g_bad_width
    $error("decoder_arb_sequencer: WIDTH_OUT must be a power of 2 and at least 2");
  end
  if (MAX_HOLD < 1 || GUARD_CYCLES < 1) begin : g_bad_count
    $error("decoder_arb_sequencer: MAX_HOLD and GUARD_CYCLES must be at least 1");
  end

  arb_state_e           state_q;
  logic [WIDTH_IN-1:0]  a_q;
  logic [WIDTH_IN-1:0]  last_owner_q;
  logic [HoldW-1:0]     hold_cnt_q;
  logic [GuardW-1:0]    guard_cnt_q;
  logic                 en1_bar_q, en2_bar_q, en3_q, grant_valid_q;

  logic                 lock;
  logic [WIDTH_IN-1:0]  arb_idx;
  logic                 arb_found;
  logic [WIDTH_OUT-1:0] others;
  logic [HoldW-1:0]     hold_inc;

`ifdef DECODER_ARB_LOCK_EN
  assign lock = Lock;
`else
  assign lock = 1'b0;
`endif

  // Search upward from last_owner+1; the index wraps naturally since WIDTH_OUT is a power of 2,
  // and the previous owner itself is the final (lowest-priority) candidate.
  always_comb begin
    arb_idx   = last_owner_q;
    arb_found = 1'b0;
    for (int i = 1; i <= int'(WIDTH_OUT); i++) begin
      logic [WIDTH_IN-1:0] cand;
      cand = last_owner_q + WIDTH_IN'(i);
      if (!arb_found && Request[cand]) begin
        arb_found = 1'b1;
        arb_idx   = cand;
      end
    end
  end

  always_comb begin
    others     = Request;
    others[a_q] = 1'b0;
    hold_inc   = (hold_cnt_q == HoldW'(MAX_HOLD)) ? hold_cnt_q : hold_cnt_q + HoldW'(1);
  end

  always_ff @(posedge Clk) begin
    if (Clear) begin
      state_q       <= StIdle;
      a_q           <= '0;
      last_owner_q  <= WIDTH_IN'(WIDTH_OUT - 1);
      hold_cnt_q    <= '0;
      guard_cnt_q   <= '0;
      en1_bar_q     <= 1'b1;
      en2_bar_q     <= 1'b1;
      en3_q         <= 1'b0;
      grant_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (arb_found) begin
            a_q          <= arb_idx;
            last_owner_q <= arb_idx;
            state_q      <= StSetup;
          end
        end
        StSetup: begin
          // Owner already latched; Request is not consulted here.
          hold_cnt_q    <= '0;
          en1_bar_q     <= 1'b0;
          en2_bar_q     <= 1'b0;
          en3_q         <= 1'b1;
          grant_valid_q <= 1'b1;
          state_q       <= StGrant;
        end
        StGrant: begin
          hold_cnt_q <= hold_inc;
          if (!Request[a_q] ||
              (hold_inc == HoldW'(MAX_HOLD) && (|others) && !lock)) begin
            en1_bar_q     <= 1'b1;
            en2_bar_q     <= 1'b1;
            en3_q         <= 1'b0;
            grant_valid_q <= 1'b0;
            guard_cnt_q   <= '0;
            state_q       <= StGuard;
          end
        end
        StGuard: begin
          if (guard_cnt_q == GuardW'(GUARD_CYCLES - 1)) begin
            if (arb_found) begin
              a_q          <= arb_idx;
              last_owner_q <= arb_idx;
              state_q      <= StSetup;
            end else begin
              state_q      <= StIdle;
            end
          end else begin
            guard_cnt_q <= guard_cnt_q + GuardW'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign A           = a_q;
  assign Enable1_bar = en1_bar_q;
  assign Enable2_bar = en2_bar_q;
  assign Enable3     = en3_q;
  assign Grant_valid = grant_valid_q;

  ttl_74238 #(
    .WIDTH_OUT  (WIDTH_OUT),
    .DELAY_RISE (DELAY_RISE),
    .DELAY_FALL (DELAY_FALL)
  ) u_decoder (
    .Enable1_bar (en1_bar_q),
    .Enable2_bar (en2_bar_q),
    .Enable3     (en3_q),
    .A           (a_q),
    .Y           (Grant)
  );

endmodule

// File: tb/tb_decoder_arb_sequencer.sv
// Bench for decoder_arb_sequencer: per-cycle vector table with an expectation queue,
// plus hand-written latency and (with DECODER_ARB_LOCK_EN) lock sequences.
module tb_decoder_arb_sequencer;

  logic       Clk = 1'b0;
  logic       Clear = 1'b1;
  logic [7:0] Request = '0;
`ifdef DECODER_ARB_LOCK_EN
  logic       Lock = 1'b0;
`endif
  logic [2:0] A;
  logic       Enable1_bar, Enable2_bar, Enable3, Grant_valid;
  logic [7:0] Grant;

  int total = 0;
  int bad   = 0;

  always #5 Clk = ~Clk;

  decoder_arb_sequencer #(
    .WIDTH_OUT    (8),
    .MAX_HOLD     (4),
    .GUARD_CYCLES (1),
    .DELAY_RISE   (0),
    .DELAY_FALL   (0)
  ) dut (
    .Clk         (Clk),
    .Clear       (Clear),
    .Request     (Request),
`ifdef DECODER_ARB_LOCK_EN
    .Lock        (Lock),
`endif
    .A           (A),
    .Enable1_bar (Enable1_bar),
    .Enable2_bar (Enable2_bar),
    .Enable3     (Enable3),
    .Grant       (Grant),
    .Grant_valid (Grant_valid)
  );

  typedef struct packed {
    logic       clr;
    logic [7:0] req;
    logic [2:0] a;
    logic       gv;
    logic [7:0] grant;
  } vec_t;

  typedef struct packed {
    logic [2:0] a;
    logic [2:0] en;   // {Enable1_bar, Enable2_bar, Enable3}
    logic [7:0] grant;
    logic       gv;
  } exp_t;

  vec_t vecs[$];
  exp_t exp_q[$];

  function automatic vec_t v(input logic clr, input logic [7:0] req, input logic [2:0] a,
                             input logic gv, input logic [7:0] grant);
    vec_t t;
    t.clr = clr; t.req = req; t.a = a; t.gv = gv; t.grant = grant;
    return t;
  endfunction

  task automatic check_out(input string name);
    exp_t e;
    exp_t act;
    e   = exp_q.pop_front();
    act = '{a: A, en: {Enable1_bar, Enable2_bar, Enable3}, grant: Grant, gv: Grant_valid};
    total++;
    if (act !== e) begin
      bad++;
      $display("FAIL %s: got A=%0d en=%b grant=%b gv=%b, want A=%0d en=%b grant=%b gv=%b",
               name, act.a, act.en, act.grant, act.gv, e.a, e.en, e.grant, e.gv);
    end
  endtask

  task automatic apply(input vec_t t, input string name);
    exp_t e;
    Request = t.req;
    Clear   = t.clr;
    e.a     = t.a;
    e.en    = t.gv ? 3'b001 : 3'b110;
    e.grant = t.grant;
    e.gv    = t.gv;
    exp_q.push_back(e);
    @(posedge Clk);
    #1;
    check_out(name);
  endtask

  // A must never move while the decoder is enabled.
  logic [2:0] prev_a = '0;
  logic       prev_en3 = 1'b0;
  always @(posedge Clk) begin
    #1;
    if (prev_en3 && Enable3) begin
      total++;
      if (A !== prev_a) begin
        bad++;
        $display("FAIL a_stable: got A=%0d while enabled, want A=%0d", A, prev_a);
      end
    end
    prev_a   = A;
    prev_en3 = Enable3;
  end

  initial begin
    int n;
    // Reset, first grant to owner 2
    vecs.push_back(v(1, 8'h00, 3'd0, 0, 8'h00));
    vecs.push_back(v(0, 8'h04, 3'd2, 0, 8'h00));
    vecs.push_back(v(0, 8'h04, 3'd2, 1, 8'h04));
    // Competitor 4 arrives: preempted after 4 GRANT cycles, 1 GUARD, SETUP, then owner 4
    vecs.push_back(v(0, 8'h14, 3'd2, 1, 8'h04));
    vecs.push_back(v(0, 8'h14, 3'd2, 1, 8'h04));
    vecs.push_back(v(0, 8'h14, 3'd2, 1, 8'h04));
    vecs.push_back(v(0, 8'h14, 3'd2, 0, 8'h00));
    vecs.push_back(v(0, 8'h14, 3'd4, 0, 8'h00));
    vecs.push_back(v(0, 8'h14, 3'd4, 1, 8'h10));
    // Owner 4 releases, owner 7 takes over
    vecs.push_back(v(0, 8'h80, 3'd4, 0, 8'h00));
    vecs.push_back(v(0, 8'h80, 3'd7, 0, 8'h00));
    vecs.push_back(v(0, 8'h80, 3'd7, 1, 8'h80));
    // Wrap-around from last_owner=7: owner 0 first, then 7
    vecs.push_back(v(0, 8'h00, 3'd7, 0, 8'h00));
    vecs.push_back(v(0, 8'h81, 3'd0, 0, 8'h00));
    vecs.push_back(v(0, 8'h81, 3'd0, 1, 8'h01));
    vecs.push_back(v(0, 8'h80, 3'd0, 0, 8'h00));
    vecs.push_back(v(0, 8'h80, 3'd7, 0, 8'h00));
    vecs.push_back(v(0, 8'h80, 3'd7, 1, 8'h80));
    // All requests drop: GUARD then IDLE with A held
    vecs.push_back(v(0, 8'h00, 3'd7, 0, 8'h00));
    vecs.push_back(v(0, 8'h00, 3'd7, 0, 8'h00));
    vecs.push_back(v(0, 8'h00, 3'd7, 0, 8'h00));
    // Clear mid-GRANT, then arbitration restarts at index 0
    vecs.push_back(v(0, 8'h20, 3'd5, 0, 8'h00));
    vecs.push_back(v(0, 8'h20, 3'd5, 1, 8'h20));
    vecs.push_back(v(1, 8'h20, 3'd0, 0, 8'h00));
    vecs.push_back(v(0, 8'h21, 3'd0, 0, 8'h00));
    vecs.push_back(v(0, 8'h21, 3'd0, 1, 8'h01));
    // Owner drops during SETUP: still one GRANT cycle, then GUARD, IDLE
    vecs.push_back(v(0, 8'h00, 3'd0, 0, 8'h00));
    vecs.push_back(v(0, 8'h02, 3'd1, 0, 8'h00));
    vecs.push_back(v(0, 8'h00, 3'd1, 1, 8'h02));
    vecs.push_back(v(0, 8'h00, 3'd1, 0, 8'h00));
    vecs.push_back(v(0, 8'h00, 3'd1, 0, 8'h00));
    // Lone owner 3 keeps the grant well past MAX_HOLD
    vecs.push_back(v(0, 8'h08, 3'd3, 0, 8'h00));
    for (int i = 0; i < 7; i++) vecs.push_back(v(0, 8'h08, 3'd3, 1, 8'h08));
    vecs.push_back(v(0, 8'h00, 3'd3, 0, 8'h00));
    vecs.push_back(v(0, 8'h00, 3'd3, 0, 8'h00));

    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i], $sformatf("vec%0d", i));
    end

    // Request-to-grant latency is two edges (bounded wait)
    Clear = 1'b1;
    @(posedge Clk);
    #1;
    Clear   = 1'b0;
    Request = 8'h40;
    n = 0;
    while (!Grant_valid && n < 10) begin
      @(posedge Clk);
      #1;
      n++;
    end
    total++;
    if (n != 2) begin
      bad++;
      $display("FAIL latency: got %0d cycles, want 2", n);
    end
    total++;
    if (Grant !== 8'h40 || A !== 3'd6) begin
      bad++;
      $display("FAIL latency_grant: got Grant=%b A=%0d, want Grant=01000000 A=6", Grant, A);
    end

`ifdef DECODER_ARB_LOCK_EN
    // Lock holds owner 0 past MAX_HOLD; dropping Lock lets owner 1 in
    apply(v(1, 8'h00, 3'd0, 0, 8'h00), "lock_reset");
    Lock = 1'b1;
    apply(v(0, 8'h03, 3'd0, 0, 8'h00), "lock_setup");
    for (int i = 0; i < 7; i++) apply(v(0, 8'h03, 3'd0, 1, 8'h01), $sformatf("lock_hold%0d", i));
    Lock = 1'b0;
    apply(v(0, 8'h03, 3'd0, 0, 8'h00), "lock_release");
    apply(v(0, 8'h03, 3'd1, 0, 8'h00), "lock_setup1");
    apply(v(0, 8'h03, 3'd1, 1, 8'h02), "lock_grant1");
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
